// File: rtl/reg_dump_streamer.sv
// reg_dump_streamer: walks the register file through one read port and
// streams each register as a {header, high byte, low byte} record over a
// valid/ready byte interface. It only ever reads the register file.

module reg_dump_streamer #(
    parameter int         NUM_REGS = 4,
    parameter logic [3:0] HDR_TAG  = 4'hA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [1:0]  rd_addr,
    input  logic [15:0] rd_data,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        HDR,
        HI,
        LO
    } state_t;

    localparam logic [1:0] LAST_IDX = 2'(NUM_REGS - 1);

    state_t      state_q;
    state_t      next_state;
    logic [1:0]  idx_q;
    logic [15:0] shadow_q;
    logic        done_q;
    logic        is_last;
    logic        last_hs;

    assign is_last = (idx_q == LAST_IDX);
    assign last_hs = (state_q == LO) && out_ready && is_last;

    // The read address simply follows the index, so it holds between captures
    assign rd_addr = idx_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // Next-state decode and the byte presented in each streaming state
    always_comb begin
        next_state = state_q;
        out_valid  = 1'b0;
        out_byte   = 8'h00;
        out_last   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    next_state = LATCH;
                end
            end
            LATCH: begin
                next_state = HDR;
            end
            HDR: begin
                out_valid = 1'b1;
                out_byte  = {HDR_TAG, 2'b00, idx_q};
                if (out_ready) begin
                    next_state = HI;
                end
            end
            HI: begin
                out_valid = 1'b1;
                out_byte  = shadow_q[15:8];
                if (out_ready) begin
                    next_state = LO;
                end
            end
            LO: begin
                out_valid = 1'b1;
                out_byte  = shadow_q[7:0];
                out_last  = is_last;
                if (out_ready) begin
                    next_state = is_last ? IDLE : LATCH;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Index restarts on every accepted start and advances after each record's low byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= 2'd0;
        end else if (state_q == IDLE && start) begin
            idx_q <= 2'd0;
        end else if (state_q == LO && out_ready && !is_last) begin
            idx_q <= idx_q + 2'd1;
        end
    end

    // Shadow captures the register value at the end of LATCH; later writes are not seen
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q <= 16'h0000;
        end else if (state_q == LATCH) begin
            shadow_q <= rd_data;
        end
    end

    // Done pulses for the single cycle following the final handshake of a frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= last_hs;
        end
    end

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Testbench for reg_dump_streamer: a register-file model feeds the read port,
// expected bytes are queued when a frame is started and compared as the DUT
// hands them over.

module tb_reg_dump_streamer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  rd_addr;
    logic [15:0] rd_data;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [15:0] regs [4];
    logic [8:0]  exp_q [$];

    int checks;
    int errors;
    int cyc;
    int hs_count;
    int done_count;
    int start_edge;
    int last_hs_edge;
    int done_edge;

    reg_dump_streamer #(
        .NUM_REGS(4),
        .HDR_TAG (4'hA)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .out_byte (out_byte),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    // Register file model: address 0 is hardwired to zero
    assign rd_data = (rd_addr == 2'd0) ? 16'h0000 : regs[rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to measure frame latency
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Queue the 12 bytes the current register contents should produce
    task automatic pushFrame();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) begin
            v = (i == 0) ? 16'h0000 : regs[i];
            exp_q.push_back({1'b0, 4'hA, 2'b00, 2'(i)});
            exp_q.push_back({1'b0, v[15:8]});
            exp_q.push_back({(i == 3), v[7:0]});
        end
    endtask

    // Start a frame: queue its expectations and pulse start for one cycle
    task automatic applyStimulus();
        pushFrame();
        start      = 1'b1;
        start_edge = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait, bounded, for the next done pulse; returns inside the done cycle
    task automatic waitDone(input int budget);
        int d0 = done_count;
        int n  = 0;
        while (done_count == d0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("done_seen", 32'(done_count - d0), 32'd1);
    endtask

    // Monitor: sampled on the falling edge, a valid&&ready here is the handshake of the next rising edge
    always @(negedge clk) begin
        if (!reset) begin
            if (!out_valid) begin
                checkOutput("byte_zero_when_invalid", {24'h0, out_byte}, 32'h0);
            end
            if (out_valid && out_ready) begin
                logic [8:0] e;
                hs_count++;
                checkOutput("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("out_byte", {24'h0, out_byte}, {24'h0, e[7:0]});
                    checkOutput("out_last", {31'h0, out_last}, {31'h0, e[8]});
                end
                if (out_last) last_hs_edge = cyc + 1;
            end
            if (done) begin
                done_count++;
                done_edge = cyc;
                checkOutput("busy_in_done", {31'h0, busy}, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int hbase;
        int dbase;
        int n;

        checks     = 0;
        errors     = 0;
        cyc        = 0;
        hs_count   = 0;
        done_count = 0;
        reset      = 1'b1;
        start      = 1'b0;
        out_ready  = 1'b1;
        regs[0]    = 16'h0000;
        regs[1]    = 16'h1234;
        regs[2]    = 16'hABCD;
        regs[3]    = 16'hFFFF;

        // Reset state
        #12;
        checkOutput("rst_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("rst_byte", {24'h0, out_byte}, 32'h0);
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_done", {31'h0, done}, 32'h0);
        checkOutput("rst_addr", {30'h0, rd_addr}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("idle_busy", {31'h0, busy}, 32'h0);

        // Full dump with ready held high
        hbase = hs_count;
        applyStimulus();
        checkOutput("busy_after_start", {31'h0, busy}, 32'h1);
        checkOutput("valid_in_latch", {31'h0, out_valid}, 32'h0);
        waitDone(100);
        checkOutput("full_latency", 32'(last_hs_edge - start_edge), 32'd16);
        checkOutput("full_done_edge", 32'(done_edge), 32'(last_hs_edge));
        checkOutput("full_hs_count", 32'(hs_count - hbase), 32'd12);
        checkOutput("full_sb_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("done_single", {31'h0, done}, 32'h0);

        // Back-pressure on reg1's high byte
        @(posedge clk);
        #1;
        applyStimulus();
        n = 0;
        while (!(out_valid && out_byte == 8'h12) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("bp_reached_hi", {24'h0, out_byte}, 32'h12);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_hold_byte", {24'h0, out_byte}, 32'h12);
            checkOutput("bp_hold_valid", {31'h0, out_valid}, 32'h1);
        end
        out_ready = 1'b1;
        waitDone(100);
        checkOutput("bp_latency", 32'(last_hs_edge - start_edge), 32'd19);
        checkOutput("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Start pulses while busy are ignored
        @(posedge clk);
        #1;
        hbase = hs_count;
        dbase = done_count;
        applyStimulus();
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(100);
        repeat (30) @(posedge clk);
        #1;
        checkOutput("busy_start_hs", 32'(hs_count - hbase), 32'd12);
        checkOutput("busy_start_done", 32'(done_count - dbase), 32'd1);

        // Start in the done cycle begins a second frame
        hbase = hs_count;
        applyStimulus();
        waitDone(100);
        checkOutput("done_now", {31'h0, done}, 32'h1);
        applyStimulus();
        checkOutput("back2back_busy", {31'h0, busy}, 32'h1);
        waitDone(100);
        checkOutput("back2back_hs", 32'(hs_count - hbase), 32'd24);
        checkOutput("back2back_sb_empty", 32'(exp_q.size()), 32'd0);

        // Register write landing on the capture edge of reg2
        @(posedge clk);
        #1;
        applyStimulus();
        while (cyc < start_edge + 8) begin
            @(posedge clk);
            #1;
        end
        checkOutput("race_addr", {30'h0, rd_addr}, 32'h2);
        checkOutput("race_latch_valid", {31'h0, out_valid}, 32'h0);
        @(posedge clk);
        regs[2] <= 16'h5555;
        #1;
        waitDone(100);
        applyStimulus();
        waitDone(100);
        checkOutput("race_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a frame
        @(posedge clk);
        #1;
        hbase = hs_count;
        applyStimulus();
        n = 0;
        while (hs_count < hbase + 5 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("mid_rst_byte", {24'h0, out_byte}, 32'h0);
        checkOutput("mid_rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("mid_rst_addr", {30'h0, rd_addr}, 32'h0);
        exp_q.delete();
        dbase = done_count;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("mid_rst_no_done", 32'(done_count - dbase), 32'd0);
        checkOutput("mid_rst_idle", {31'h0, out_valid}, 32'h0);
        hbase = hs_count;
        applyStimulus();
        waitDone(100);
        checkOutput("post_rst_hs", 32'(hs_count - hbase), 32'd12);
        checkOutput("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
